// File: rtl/jit_emit_seq.sv
// Template expansion sequencer: walks consecutive instruction ids through the
// combinational template ROM and streams the returned ARM words with their code addresses.
module jit_emit_seq #(
   parameter int LEN_W = 4,
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [6:0]       req_start,
   input  logic [LEN_W-1:0] req_len,
   input  logic             pc_load,
   input  logic [PC_W-1:0]  pc_in,
   output logic [6:0]       rom_addr,
   input  logic [31:0]      rom_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [PC_W-1:0]  out_pc,
   output logic             done,
   output logic             err_rom,
   output logic             err_range,
   input  logic             clr_err,
   output logic [CNT_W-1:0] word_cnt
);

   // Wide enough for start id (7 bits) plus length without overflow.
   localparam int SUM_W = ((LEN_W > 7) ? LEN_W : 7) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EMIT = 2'd1,
      S_ERR  = 2'd2
   } state_e;

   state_e           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [6:0]       cur_id_q;
   logic [LEN_W-1:0] rem_q;
   logic             out_valid_q;
   logic [31:0]      out_data_q;
   logic [PC_W-1:0]  out_pc_q;
   logic             done_q;
   logic             err_rom_q;
   logic             err_range_q;
   logic [CNT_W-1:0] word_cnt_q;

   logic [SUM_W-1:0] req_end_d;
   logic             range_bad_d;
   logic             req_fire_d;
   logic             capture_d;
   logic             rom_bad_d;
   logic             unused_pc_lsb;

   assign unused_pc_lsb = ^pc_in[1:0];

   assign req_ready   = (state_q == S_IDLE) && !err_rom_q && !err_range_q;
   assign req_fire_d  = req_valid && req_ready;
   assign req_end_d   = SUM_W'(req_start) + SUM_W'(req_len);
   assign range_bad_d = req_end_d > SUM_W'(128);
   assign capture_d   = !out_valid_q || out_ready;
   assign rom_bad_d   = (rom_data == 32'hFFFF_FFFF);

   assign rom_addr  = cur_id_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_pc    = out_pc_q;
   assign done      = done_q;
   assign err_rom   = err_rom_q;
   assign err_range = err_range_q;
   assign word_cnt  = word_cnt_q;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; later assignments in the block deliberately override earlier defaults.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         cur_id_q    <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_pc_q    <= '0;
         done_q      <= 1'b0;
         err_rom_q   <= 1'b0;
         err_range_q <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         // A flag raised in the same cycle as clr_err wins over the clear.
         if (clr_err) begin
            err_rom_q   <= 1'b0;
            err_range_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (pc_load) pc_q <= {pc_in[PC_W-1:2], 2'b00};
               if (req_fire_d) begin
                  if (range_bad_d) begin
                     err_range_q <= 1'b1;
                     state_q     <= S_ERR;
                  end else if (req_len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     cur_id_q <= req_start;
                     rem_q    <= req_len;
                     state_q  <= S_EMIT;
                  end
               end
            end
            S_EMIT: begin
               if (capture_d) begin
                  if (rom_bad_d) begin
                     err_rom_q <= 1'b1;
                     state_q   <= S_ERR;
                  end else begin
                     out_data_q  <= rom_data;
                     out_pc_q    <= pc_q;
                     out_valid_q <= 1'b1;
                     pc_q        <= pc_q + PC_W'(4);
                     cur_id_q    <= cur_id_q + 7'd1;
                     rem_q       <= rem_q - LEN_W'(1);
                     word_cnt_q  <= word_cnt_q + CNT_W'(1);
                     if (rem_q == LEN_W'(1)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                     end
                  end
               end
            end
            S_ERR: begin
               if (clr_err) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jit_emit_seq.sv
// Randomised scoreboard bench for jit_emit_seq: a template-level model predicts
// the emitted (word, address) stream and a monitor checks each handshake.
module tb_jit_emit_seq;

   localparam int LEN_W = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [6:0]       req_start = '0;
   logic [LEN_W-1:0] req_len = '0;
   logic             pc_load = 1'b0;
   logic [PC_W-1:0]  pc_in = '0;
   logic [6:0]       rom_addr;
   logic [31:0]      rom_data;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [31:0]      out_data;
   logic [PC_W-1:0]  out_pc;
   logic             done;
   logic             err_rom;
   logic             err_range;
   logic             clr_err = 1'b0;
   logic [CNT_W-1:0] word_cnt;

   jit_emit_seq #(.LEN_W(LEN_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_start(req_start), .req_len(req_len),
      .pc_load(pc_load), .pc_in(pc_in),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_pc(out_pc),
      .done(done), .err_rom(err_rom), .err_range(err_range),
      .clr_err(clr_err), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   // Template ROM contents; ids 0x43 and 0x60 are undefined.
   function automatic logic [31:0] rom_fn(input logic [6:0] id);
      case (id)
         7'h01:        return 32'hE49D_0004;
         7'h02:        return 32'hE52D_0004;
         7'h03:        return 32'hE8BD_0003;
         7'h42:        return 32'hED80_0B00;
         7'h43, 7'h60: return 32'hFFFF_FFFF;
         default:      return 32'hE280_0000 | {25'd0, id};
      endcase
   endfunction

   assign rom_data = rom_fn(rom_addr);

   typedef struct packed {
      logic [31:0]     data;
      logic [PC_W-1:0] pc;
   } word_t;

   word_t            exp_q[$];
   int               hs_cyc[$];
   int               n_checks = 0;
   int               n_pass = 0;
   int               cyc = 0;
   int               stall_pct = 0;
   logic             rst_at_edge = 1'b1;
   logic [PC_W-1:0]  m_pc = '0;
   logic [CNT_W-1:0] m_cnt = '0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) begin
      cyc++;
      rst_at_edge = !rst_n;
   end

   always @(posedge clk) begin
      #1;
      out_ready = ($urandom_range(99) >= stall_pct);
   end

   // Monitor: pops the scoreboard on each handshake and checks stall stability.
   logic            p_valid = 1'b0;
   logic            p_ready = 1'b0;
   logic [31:0]     p_data = '0;
   logic [PC_W-1:0] p_pc = '0;
   always @(negedge clk) begin
      word_t w;
      if (p_valid && !p_ready && !rst_at_edge)
         check("hold_stable", {out_valid, out_data, out_pc}, {1'b1, p_data, p_pc});
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got %0h@%0h expected none", out_data, out_pc);
         end else begin
            w = exp_q.pop_front();
            check("word", {out_data, out_pc}, {w.data, w.pc});
         end
         hs_cyc.push_back(cyc);
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_data  = out_data;
      p_pc    = out_pc;
   end

   task automatic drain();
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain", 96'(exp_q.size()), 96'd0);
      @(negedge clk);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
      check("req_ready_wait", 96'(req_ready), 96'd1);
   endtask

   task automatic clear_err();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("clr_err", {err_rom, err_range, req_ready}, 96'b001);
   endtask

   // Issues one template request and checks its completion against the model.
   task automatic do_req(input logic [6:0] start, input logic [LEN_W-1:0] len,
                         input bit load, input logic [PC_W-1:0] pcv,
                         input bit lat_chk, input bit emit_load, input bit hold_first);
      int    kind;
      int    n;
      int    acc;
      int    first;
      bit    loaded;
      word_t nw;
      logic [31:0] last;
      logic [6:0]  id;
      drain();
      wait_ready();
      if (load) m_pc = {pcv[PC_W-1:2], 2'b00};
      kind = 0;
      n    = 0;
      last = '0;
      if (int'(start) + int'(len) > 128) kind = 2;
      else begin
         for (int i = 0; i < int'(len); i++) begin
            id = start + 7'(i);
            if (rom_fn(id) == 32'hFFFF_FFFF) begin
               kind = 1;
               break;
            end
            nw.data = rom_fn(id);
            nw.pc   = m_pc;
            exp_q.push_back(nw);
            last  = nw.data;
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 16'd1;
            n++;
         end
      end
      if (hold_first) stall_pct = 100;
      req_valid = 1'b1;
      req_start = start;
      req_len   = len;
      pc_load   = load;
      pc_in     = pcv;
      @(posedge clk);
      #1;
      acc       = cyc;
      req_valid = 1'b0;
      pc_load   = 1'b0;
      first     = -1;
      loaded    = 1'b0;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         if (pc_load) pc_load = 1'b0;
         if (out_valid && first < 0) begin
            first = cyc;
            if (emit_load && !loaded) begin
               pc_load = 1'b1;
               pc_in   = 32'hDEAD_0000;
               loaded  = 1'b1;
            end
         end
         if (hold_first && first >= 0 && cyc == first + 2) stall_pct = 0;
         if (done || err_rom || err_range) break;
      end
      pc_load = 1'b0;
      if (kind == 0) begin
         check("done", {done, err_rom, err_range}, 96'b100);
         check("done_with_word", 96'(out_valid), 96'(n > 0));
         if (n > 0) check("done_last_word", 96'(out_data), 96'(last));
         check("word_cnt", 96'(word_cnt), 96'(m_cnt));
         if (lat_chk) check("latency", 96'(first), 96'(acc + 1));
         @(negedge clk);
         check("done_pulse", 96'(done), 96'd0);
      end else begin
         check(kind == 1 ? "err_rom" : "err_range",
               {err_rom, err_range, done, req_ready}, kind == 1 ? 96'b1000 : 96'b0100);
         check("err_word_cnt", 96'(word_cnt), 96'(m_cnt));
         drain();
         check("err_sticky", {err_rom, err_range, req_ready}, kind == 1 ? 96'b100 : 96'b010);
         clear_err();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok_quiet;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {req_ready, out_valid, done, err_rom, err_range}, 96'b10000);
      check("reset_data", {word_cnt, rom_addr, out_data, out_pc}, 96'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic template with unaligned pc load and an ignored pc_load during EMIT.
      do_req(7'h01, 4'd3, 1'b1, 32'h0000_1003, 1'b1, 1'b1, 1'b0);

      // Consumer stall on the first word.
      drain();
      hs_cyc.delete();
      do_req(7'h01, 4'd3, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      drain();
      check("stall_consecutive", {32'(hs_cyc.size()), 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0])},
            {32'd3, 32'd2});

      // Undefined ROM id, range limit just above and at 128, zero length, pc wrap.
      do_req(7'h42, 4'd2, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      do_req(7'h7E, 4'd4, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      do_req(7'h7E, 4'd2, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      do_req(7'h05, 4'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      do_req(7'h10, 4'd4, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a template.
      drain();
      wait_ready();
      for (int i = 0; i < 3; i++) begin
         word_t nw;
         nw.data = rom_fn(7'(1 + i));
         nw.pc   = m_pc + 32'(4 * i);
         exp_q.push_back(nw);
      end
      req_valid = 1'b1;
      req_start = 7'h01;
      req_len   = 4'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      m_pc  = '0;
      m_cnt = '0;
      @(negedge clk);
      check("midreset_state", {out_valid, req_ready, done, err_rom, err_range}, 96'b01000);
      check("midreset_regs", {word_cnt, out_pc}, 96'd0);
      ok_quiet = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) ok_quiet = 1'b0;
      end
      check("midreset_quiet", 96'(ok_quiet), 96'd1);
      do_req(7'h01, 4'd3, 1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Randomised templates with random consumer back-pressure.
      for (int r = 0; r < 40; r++) begin
         logic [6:0]       s;
         logic [LEN_W-1:0] l;
         bit               ld;
         int               sp;
         s  = 7'($urandom_range(127));
         l  = LEN_W'($urandom_range(15));
         ld = ($urandom_range(3) == 0);
         sp = $urandom_range(2) * 30;
         stall_pct = sp;
         do_req(s, l, ld, $urandom, 1'b0, 1'b0, 1'b0);
      end
      stall_pct = 0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
